sv_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among eight requesters. It reuses the 8-request, 3-bit-grant convention of the codebase's priority encoder, but replaces fixed priority with a rotating pointer. It adds registered grant ownership, so a requester keeps the grant until it drops its request or exceeds a maximum hold time. It sits between the requesting agents and the shared datapath, and drives the datapath's select and enable.

---
 rtl/sv_rr_arbiter.sv | 118 +++++++++++
 tb/tb_sv_rr_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sv_rr_arbiter.sv
// Eight-way round-robin arbiter with registered grant ownership and a
// maximum hold time; drives the shared datapath select and enable.
module sv_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] request,
  output logic [7:0] grant_onehot,
  output logic [2:0] grant,
  output logic       valid,
  output logic       timeout
);

  localparam int unsigned NREQ = 8;
  localparam int unsigned IDXW = 3;
  localparam int unsigned CNTW = 8;
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);
  localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q;
  logic [IDXW-1:0]  ptr_q;
  logic [IDXW-1:0]  owner_q;
  logic [CNTW-1:0]  hold_cnt_q;
  logic [NREQ-1:0]  grant_onehot_q;
  logic [IDXW-1:0]  grant_q;
  logic             valid_q;
  logic             timeout_q;

  logic             win_found_c;
  logic [IDXW-1:0]  win_idx_c;
  logic [IDXW-1:0]  ptr_d;
  logic [NREQ-1:0]  win_onehot_c;
  logic             expire_c;
  logic             release_c;
  logic [IDXW-1:0]  scan_idx;

  // Rotating-priority scan starting at the favoured index.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    scan_idx    = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      scan_idx = ptr_q + IDXW'(i);
      if (!win_found_c && request[scan_idx]) begin
        win_found_c = 1'b1;
        win_idx_c   = scan_idx;
      end
    end
  end

  always_comb begin
    ptr_d        = win_idx_c + IDXW'(1);
    win_onehot_c = ONE_HOT0 << win_idx_c;
    // A timeout is a forced loss: the owner still wanted the resource.
    expire_c     = (state_q == BUSY) && request[owner_q] && (hold_cnt_q == HOLD_LAST);
    release_c    = (state_q == BUSY) && (!request[owner_q] || (hold_cnt_q == HOLD_LAST));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      owner_q        <= '0;
      hold_cnt_q     <= '0;
      grant_onehot_q <= '0;
      grant_q        <= '0;
      valid_q        <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      timeout_q <= expire_c;
      case (state_q)
        IDLE: begin
          if (win_found_c) begin
            state_q        <= BUSY;
            owner_q        <= win_idx_c;
            grant_q        <= win_idx_c;
            grant_onehot_q <= win_onehot_c;
            valid_q        <= 1'b1;
            hold_cnt_q     <= '0;
            ptr_q          <= ptr_d;
          end
        end
        BUSY: begin
          if (!release_c) begin
            hold_cnt_q <= hold_cnt_q + CNTW'(1);
          end else if (win_found_c) begin
            // Back-to-back handover keeps valid high with no idle bubble.
            owner_q        <= win_idx_c;
            grant_q        <= win_idx_c;
            grant_onehot_q <= win_onehot_c;
            valid_q        <= 1'b1;
            hold_cnt_q     <= '0;
            ptr_q          <= ptr_d;
          end else begin
            state_q        <= IDLE;
            grant_q        <= '0;
            grant_onehot_q <= '0;
            valid_q        <= 1'b0;
            hold_cnt_q     <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_onehot = grant_onehot_q;
  assign grant        = grant_q;
  assign valid        = valid_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_sv_rr_arbiter.sv
// Directed self-checking bench for sv_rr_arbiter with hand-computed grants.
module tb_sv_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] request;
  logic [7:0] grant_onehot;
  logic [2:0] grant;
  logic       valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  sv_rr_arbiter #(.MAX_HOLD(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .request      (request),
    .grant_onehot (grant_onehot),
    .grant        (grant),
    .valid        (valid),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] g, input logic v, input logic t);
    logic [7:0] oh;
    oh = v ? (8'h01 << g) : 8'h00;
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".onehot"}, 32'(grant_onehot), 32'(oh));
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    rst     = 1'b1;
    request = 8'h00;
    cyc();
    cyc();
    chk_out("reset", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc();
    chk_out("idle_after_reset", 3'd0, 1'b0, 1'b0);

    // Single requester 3 held for five edges, then dropped.
    request = 8'h08;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_out($sformatf("single_%0d", k), 3'd3, 1'b1, 1'b0);
    end
    request = 8'h00;
    cyc();
    chk_out("single_drop", 3'd0, 1'b0, 1'b0);

    // Pointer is 4 now; async reset mid-grant.
    request = 8'hFF;
    cyc();
    chk_out("pre_reset_grant", 3'd4, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_reset", 3'd0, 1'b0, 1'b0);
    cyc();
    rst     = 1'b0;
    request = 8'h00;
    cyc();
    chk_out("post_reset_0", 3'd0, 1'b0, 1'b0);
    cyc();
    chk_out("post_reset_1", 3'd0, 1'b0, 1'b0);

    // Rotation from ptr 0: each owner drops its bit after two granted cycles.
    request = 8'hFF;
    cyc();
    chk_out("rot_first", 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk_out($sformatf("rot_hold_%0d", i), 3'(i), 1'b1, 1'b0);
      request = 8'hFF & ~(8'h01 << i);
      cyc();
      chk_out($sformatf("rot_next_%0d", i), 3'((i + 1) % 8), 1'b1, 1'b0);
      request = 8'hFF;
    end
    request = 8'h00;
    cyc();
    chk_out("rot_idle", 3'd0, 1'b0, 1'b0);

    // Pointer skip: ptr=1, grant 5, then request 0 and 2.
    request = 8'h20;
    cyc();
    chk_out("skip_own5", 3'd5, 1'b1, 1'b0);
    request = 8'h05;
    cyc();
    chk_out("skip_to0", 3'd0, 1'b1, 1'b0);
    request = 8'h04;
    cyc();
    chk_out("skip_to2", 3'd2, 1'b1, 1'b0);
    request = 8'h00;
    cyc();
    chk_out("skip_idle", 3'd0, 1'b0, 1'b0);

    // Timeout handover: ptr=3, requesters 5 and 2.
    request = 8'h24;
    for (int k = 0; k < 16; k++) begin
      cyc();
      chk_out($sformatf("to_own5_%0d", k), 3'd5, 1'b1, 1'b0);
    end
    cyc();
    chk_out("to_handover", 3'd2, 1'b1, 1'b1);
    cyc();
    chk_out("to_after", 3'd2, 1'b1, 1'b0);
    request = 8'h00;
    cyc();
    chk_out("to_idle", 3'd0, 1'b0, 1'b0);

    // Lone requester 4 repeatedly times out and is re-granted.
    request = 8'h10;
    for (int n = 0; n < 40; n++) begin
      cyc();
      chk_out($sformatf("lone_%0d", n), 3'd4, 1'b1, (n == 16) || (n == 32));
    end
    request = 8'h00;
    cyc();
    chk_out("lone_idle", 3'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
